// File: rtl/dircc_counter_multi_send_handler_if.sv
// Handshake bundle between the device-state read port, the packet queue and the
// write-back port of the counter multi-send handler.
interface dircc_counter_multi_send_handler_if #(
    parameter int unsigned MEM_ADDRESS_WIDTH       = 32,
    parameter int unsigned NUM_PINS                = 4,
    parameter int unsigned COUNT_WIDTH             = 16,
    parameter int unsigned PACKET_WIDTH            = 96,
    parameter int unsigned USER_STATE_WIDTH        = 64,
    parameter int unsigned DIRCC_STATE_WIDTH       = 32,
    parameter int unsigned DIRCC_STATE_EXTRA_WIDTH = 32
) ();
    typedef struct packed {
        logic [DIRCC_STATE_EXTRA_WIDTH-1:0] dircc_state_extra;
        logic [DIRCC_STATE_WIDTH-1:0]       dircc_state;
        logic [USER_STATE_WIDTH-1:0]        user_state;
    } device_state_t;

    logic [MEM_ADDRESS_WIDTH-1:0] address;
    device_state_t                read_state;
    logic                         read_state_valid;
    logic                         busy;
    logic [PACKET_WIDTH-1:0]      packet_out;
    logic                         packet_out_valid;
    logic                         packet_out_ready;
    device_state_t                write_state;
    logic                         write_state_valid;
    logic                         done;

    modport master (
        output address, read_state, read_state_valid, packet_out_ready,
        input  busy, packet_out, packet_out_valid, write_state, write_state_valid, done
    );

    modport slave (
        input  address, read_state, read_state_valid, packet_out_ready,
        output busy, packet_out, packet_out_valid, write_state, write_state_valid, done
    );
endinterface

// File: rtl/dircc_counter_multi_send_handler.sv
// Drains the RTS mask of one device-state snapshot, one packet per set pin (lowest first),
// then writes the state back once with the mask cleared and the counter advanced.
module dircc_counter_multi_send_handler #(
    parameter int unsigned MEM_ADDRESS_WIDTH       = 32,
    parameter int unsigned NUM_PINS                = 4,
    parameter int unsigned COUNT_WIDTH             = 16,
    parameter int unsigned PACKET_WIDTH            = 96,
    parameter int unsigned USER_STATE_WIDTH        = 64,
    parameter int unsigned DIRCC_STATE_WIDTH       = 32,
    parameter int unsigned DIRCC_STATE_EXTRA_WIDTH = 32
) (
    input logic                              clk,
    input logic                              reset_n,
    dircc_counter_multi_send_handler_if.slave bus
);
    typedef struct packed {
        logic [DIRCC_STATE_EXTRA_WIDTH-1:0] dircc_state_extra;
        logic [DIRCC_STATE_WIDTH-1:0]       dircc_state;
        logic [USER_STATE_WIDTH-1:0]        user_state;
    } device_state_t;

    typedef enum logic [1:0] {StIdle, StSend, StWrite} state_e;

    state_e                       state_q;
    device_state_t                snap_q;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_q;
    logic [NUM_PINS-1:0]          mask_q;
    logic [COUNT_WIDTH-1:0]       count_q;
    logic                         busy_q;
    logic [PACKET_WIDTH-1:0]      packet_q;
    logic                         packet_valid_q;
    device_state_t                write_state_q;
    logic                         write_valid_q;
    logic                         done_q;

    logic [NUM_PINS-1:0]    rd_mask;
    logic [COUNT_WIDTH-1:0] rd_count;
    logic [NUM_PINS-1:0]    mask_next;
    logic [COUNT_WIDTH-1:0] count_next;
    device_state_t          wb_next;

    function automatic logic [7:0] lowest_pin(input logic [NUM_PINS-1:0] m);
        logic [7:0] r;
        r = '0;
        for (int i = int'(NUM_PINS) - 1; i >= 0; i--) begin
            if (m[i]) r = 8'(i);
        end
        return r;
    endfunction

    function automatic logic [PACKET_WIDTH-1:0] make_packet(
        input logic [7:0]                   pin,
        input logic [COUNT_WIDTH-1:0]       cnt,
        input logic [MEM_ADDRESS_WIDTH-1:0] a
    );
        logic [PACKET_WIDTH-1:0] p;
        p = '0;
        p[COUNT_WIDTH-1:0]            = cnt;
        p[39:32]                      = pin;
        p[MEM_ADDRESS_WIDTH+39:40]    = a;
        return p;
    endfunction

    assign rd_mask    = bus.read_state.user_state[COUNT_WIDTH+NUM_PINS-1:COUNT_WIDTH];
    assign rd_count   = bus.read_state.user_state[COUNT_WIDTH-1:0];
    // Clearing the lowest set bit is exactly the pin being sent.
    assign mask_next  = mask_q & (mask_q - NUM_PINS'(1));
    assign count_next = count_q + COUNT_WIDTH'(1);

    always_comb begin
        wb_next = snap_q;
        wb_next.user_state[COUNT_WIDTH-1:0]                    = count_next;
        wb_next.user_state[COUNT_WIDTH+NUM_PINS-1:COUNT_WIDTH] = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            snap_q         <= '0;
            addr_q         <= '0;
            mask_q         <= '0;
            count_q        <= '0;
            busy_q         <= 1'b0;
            packet_q       <= '0;
            packet_valid_q <= 1'b0;
            write_state_q  <= '0;
            write_valid_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.read_state_valid) begin
                        snap_q  <= bus.read_state;
                        addr_q  <= bus.address;
                        mask_q  <= rd_mask;
                        count_q <= rd_count;
                        if (rd_mask != '0) begin
                            state_q        <= StSend;
                            busy_q         <= 1'b1;
                            packet_q       <= make_packet(lowest_pin(rd_mask), rd_count,
                                                          bus.address);
                            packet_valid_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (packet_valid_q && bus.packet_out_ready) begin
                        mask_q  <= mask_next;
                        count_q <= count_next;
                        if (mask_next == '0) begin
                            packet_valid_q <= 1'b0;
                            write_state_q  <= wb_next;
                            write_valid_q  <= 1'b1;
                            done_q         <= 1'b1;
                            state_q        <= StWrite;
                        end else begin
                            packet_q <= make_packet(lowest_pin(mask_next), count_next, addr_q);
                        end
                    end
                end
                StWrite: begin
                    write_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.packet_out        = packet_q;
    assign bus.packet_out_valid  = packet_valid_q;
    assign bus.write_state       = write_state_q;
    assign bus.write_state_valid = write_valid_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_dircc_counter_multi_send_handler.sv
// Scoreboard bench: stimulus pushes expected packets/write-backs, a negedge monitor pops and
// compares them whenever the handler presents output.
module tb_dircc_counter_multi_send_handler;
    localparam int AW = 32;
    localparam int NP = 4;
    localparam int CW = 16;
    localparam int PW = 96;
    localparam int UW = 64;
    localparam int DW = 32;
    localparam int EW = 32;
    localparam int SW = UW + DW + EW;

    typedef struct packed {
        logic [EW-1:0] dircc_state_extra;
        logic [DW-1:0] dircc_state;
        logic [UW-1:0] user_state;
    } dstate_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dircc_counter_multi_send_handler_if #(
        .MEM_ADDRESS_WIDTH(AW), .NUM_PINS(NP), .COUNT_WIDTH(CW), .PACKET_WIDTH(PW),
        .USER_STATE_WIDTH(UW), .DIRCC_STATE_WIDTH(DW), .DIRCC_STATE_EXTRA_WIDTH(EW)
    ) bus ();

    dircc_counter_multi_send_handler #(
        .MEM_ADDRESS_WIDTH(AW), .NUM_PINS(NP), .COUNT_WIDTH(CW), .PACKET_WIDTH(PW),
        .USER_STATE_WIDTH(UW), .DIRCC_STATE_WIDTH(DW), .DIRCC_STATE_EXTRA_WIDTH(EW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] pkt_q[$];
    logic [SW-1:0] wb_q[$];
    bit            done_kind_q[$];

    bit            mon_en     = 1'b0;
    int            ready_mode = 0;
    int            low_cnt    = 0;
    bit            holding    = 1'b0;
    logic [PW-1:0] held;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input string info);
        total++;
        bad++;
        $display("FAIL %s: %s", name, info);
    endtask

    function automatic logic [PW-1:0] exp_pkt(input int pin, input longint cnt,
                                              input logic [AW-1:0] addr);
        logic [PW-1:0] p;
        logic [31:0]   c;
        logic [7:0]    pn;
        c  = cnt[31:0];
        pn = pin[7:0];
        p  = '0;
        p[31:0]     = c;
        p[39:32]    = pn;
        p[40 +: AW] = addr;
        return p;
    endfunction

    // Reference model: walk the mask in pin order, counter modulo 2^CW.
    task automatic push_expect(input logic [NP-1:0] mask, input dstate_t s,
                               input logic [AW-1:0] addr);
        longint     base;
        longint     modv;
        int         k;
        logic [63:0] user;
        dstate_t    w;
        modv = longint'(1) << CW;
        base = longint'(s.user_state[CW-1:0]);
        k    = 0;
        for (int i = 0; i < NP; i++) begin
            if (mask[i]) begin
                pkt_q.push_back(exp_pkt(i, (base + k) % modv, addr));
                k++;
            end
        end
        if (k == 0) begin
            done_kind_q.push_back(1'b0);
        end else begin
            user = s.user_state;
            user = (user >> (CW + NP)) << (CW + NP);
            user = user | 64'((base + k) % modv);
            w = s;
            w.user_state = user;
            wb_q.push_back(w);
            done_kind_q.push_back(1'b1);
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_busy"}, bus.busy, 0);
        chk({pfx, "_packet_out"}, bus.packet_out, 0);
        chk({pfx, "_packet_out_valid"}, bus.packet_out_valid, 0);
        chk({pfx, "_write_state"}, bus.write_state, 0);
        chk({pfx, "_write_state_valid"}, bus.write_state_valid, 0);
        chk({pfx, "_done"}, bus.done, 0);
    endtask

    // Drives one snapshot and returns at the cycle-1 negedge after checking its latency.
    task automatic issue(input logic [NP-1:0] mask, input int count, input logic [AW-1:0] addr);
        dstate_t s;
        s.dircc_state_extra   = $urandom;
        s.dircc_state         = $urandom;
        s.user_state          = {$urandom, $urandom};
        s.user_state[CW-1:0]  = count[CW-1:0];
        s.user_state[CW+NP-1:CW] = mask;
        push_expect(mask, s, addr);
        bus.address          = addr;
        bus.read_state       = s;
        bus.read_state_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.read_state_valid = 1'b0;
        @(negedge clk);
        if (mask != '0) begin
            chk("lat_busy", bus.busy, 1);
            chk("lat_packet_valid", bus.packet_out_valid, 1);
        end else begin
            chk("zero_done", bus.done, 1);
            chk("zero_busy", bus.busy, 0);
            chk("zero_no_packet", bus.packet_out_valid, 0);
            chk("zero_no_write", bus.write_state_valid, 0);
        end
    endtask

    task automatic wait_finish(inout int cyc);
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", bus.done, 1);
        @(negedge clk);
        chk("idle_after_write", bus.busy, 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.packet_out_ready = 1'b1;
            1: bus.packet_out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                bus.packet_out_ready = (low_cnt == 0);
                if (low_cnt > 0 && bus.packet_out_valid) low_cnt--;
            end
        endcase
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.packet_out_valid) begin
                if (holding) chk("hold_stable", bus.packet_out, held);
                if (bus.packet_out_ready) begin
                    holding = 1'b0;
                    if (pkt_q.size() == 0) fail_now("unexpected_packet", $sformatf("%h", bus.packet_out));
                    else chk("packet", bus.packet_out, pkt_q.pop_front());
                end else begin
                    holding = 1'b1;
                    held    = bus.packet_out;
                end
            end else if (holding) begin
                fail_now("valid_dropped", "packet_out_valid fell without handshake");
                holding = 1'b0;
            end
            if (bus.done) begin
                if (done_kind_q.size() == 0) fail_now("unexpected_done", "done with nothing pending");
                else chk("done_with_write", bus.write_state_valid, done_kind_q.pop_front());
            end
            if (bus.write_state_valid) begin
                if (wb_q.size() == 0) fail_now("unexpected_write", $sformatf("%h", bus.write_state));
                else chk("write_state", bus.write_state, wb_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [NP-1:0] m;
        int cnt;
        dstate_t junk;
        reset_n              = 1'b0;
        bus.address          = '0;
        bus.read_state       = '0;
        bus.read_state_valid = 1'b0;
        bus.packet_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single pin, ready high: write at cycle 2.
        ready_mode = 0;
        issue(4'b0001, 5, 32'h1000);
        cyc = 1;
        wait_finish(cyc);
        chk("single_pin_done_cycle", cyc, 2);

        // Three packets back to back.
        issue(4'b1011, 10, 32'h2000);
        cyc = 1;
        wait_finish(cyc);
        chk("three_pin_done_cycle", cyc, 4);

        // Ready held low for three cycles.
        ready_mode = 2;
        low_cnt    = 3;
        issue(4'b0110, 40, 32'h3000);
        cyc = 1;
        wait_finish(cyc);
        chk("stall_done_cycle", cyc, 6);
        ready_mode = 0;

        // Zero mask, then a second snapshot in cycle 1.
        issue(4'b0000, 7, 32'h4000);
        issue(4'b0101, 3, 32'h4004);
        cyc = 1;
        wait_finish(cyc);

        // Counter wrap.
        issue(4'b0011, 16'hFFFF, 32'h5000);
        cyc = 1;
        wait_finish(cyc);

        // Snapshot strobe while busy must be ignored.
        ready_mode = 1;
        issue(4'b1011, 100, 32'h6000);
        junk = '0;
        junk.user_state[CW+NP-1:CW] = 4'b1111;
        bus.read_state       = junk;
        bus.read_state_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.read_state_valid = 1'b0;
        @(negedge clk);
        cyc = 2;
        wait_finish(cyc);

        // Reset while the second packet is presented.
        ready_mode = 0;
        issue(4'b0111, 20, 32'h7000);
        @(posedge clk);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_second_packet_pin", bus.packet_out[39:32], 1);
        @(negedge clk);
        chk_outputs_zero("midreset");
        pkt_q.delete();
        wb_q.delete();
        done_kind_q.delete();
        holding = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        issue(4'b1001, 55, 32'h8000);
        cyc = 1;
        wait_finish(cyc);

        // Randomised traffic with random back-pressure.
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            m   = 4'($urandom_range(0, 15));
            cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFFFC, 16'hFFFF))
                                               : int'($urandom_range(0, 16'hFFFF));
            issue(m, cnt, $urandom);
            if (m != '0) begin
                cyc = 1;
                wait_finish(cyc);
            end
        end

        ready_mode = 0;
        repeat (4) @(negedge clk);
        chk("pkt_queue_drained", pkt_q.size(), 0);
        chk("write_queue_drained", wb_q.size(), 0);
        chk("done_queue_drained", done_kind_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
